nuc970_corrector: RTL and testbench

NUC970_CORRECTOR -- requirements
Module: nuc970_corrector

---
 rtl/nuc970_corrector.sv | 170 +++++++++++++++++
 tb/tb_nuc970_corrector.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nuc970_corrector.sv
// Buffers one NAND codeword and applies the decoder's per-byte error masks to it.
// Latency: corrected byte k is presented one cycle after err_in for byte k; output runs gap-free.
// No backpressure: the corrected stream is emitted at the decoder's error-mask rate.
module nuc970_corrector #(
  parameter int DATA_BYTES = 536,
  parameter int BITS       = 8,
  parameter int T          = 4
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic [BITS-1:0] data_in,
  input  logic            data_start,
  input  logic [BITS-1:0] err_in,
  input  logic            err_first,
  input  logic [7:0]      err_cnt,
  input  logic            err_last,
  output logic [BITS-1:0] data_out,
  output logic            out_valid,
  output logic            out_first,
  output logic            out_last,
  output logic [7:0]      corr_cnt,
  output logic            fail,
  output logic            done,
  output logic            proto_err
);

  localparam int PW = $clog2(DATA_BYTES + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DATA_BYTES - 1);
  localparam logic [PW-1:0] END_PTR  = PW'(DATA_BYTES);

  typedef enum logic [2:0] {IDLE, FILL, WAIT, CORRECT, DONE} state_t;

  state_t          state;
  logic [BITS-1:0] mem [DATA_BYTES];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [7:0]      dec_cnt;
  logic            last_seen;

  logic            start_ok;
  logic            fill_busy;
  logic            wr_en;
  logic [PW-1:0]   wr_addr;
  logic            corr_go;
  logic            corr_step;
  logic [PW-1:0]   rd_idx;
  logic [BITS-1:0] rd_byte;
  logic [7:0]      err_ones;
  logic [8:0]      corr_sum;
  logic [7:0]      corr_nxt;
  logic [7:0]      dec_nxt;
  logic            seen_nxt;
  logic            fail_nxt;
  logic            proto_hit;

  // Decode this cycle's buffer access, correction step and end-of-page verdict.
  always_comb begin
    start_ok  = data_start && (state == IDLE || state == DONE);
    // The fill keeps running underneath WAIT/CORRECT until every byte is buffered.
    fill_busy = (wr_ptr != '0) && (wr_ptr < END_PTR);
    wr_en     = start_ok || fill_busy;
    wr_addr   = start_ok ? '0 : wr_ptr;
    corr_go   = err_first && (state == FILL || state == WAIT);
    corr_step = corr_go || (state == CORRECT);
    rd_idx    = (rd_ptr < END_PTR) ? rd_ptr : '0;
    // Same-address read during a write returns the byte being written.
    rd_byte   = (wr_en && wr_addr == rd_idx) ? data_in : mem[rd_idx];
    err_ones  = '0;
    for (int i = 0; i < BITS; i++) begin
      err_ones = err_ones + 8'(err_in[i]);
    end
    corr_sum  = {1'b0, corr_cnt} + {1'b0, err_ones};
    corr_nxt  = corr_cnt;
    if (corr_step) begin
      corr_nxt = corr_sum[8] ? 8'hFF : corr_sum[7:0];
    end
    dec_nxt   = dec_cnt;
    seen_nxt  = last_seen;
    if (err_last && state != IDLE) begin
      dec_nxt  = err_cnt;
      seen_nxt = 1'b1;
    end
    fail_nxt  = (dec_nxt > 8'(T)) || (dec_nxt != corr_nxt) || !seen_nxt;
    // A byte-0 mask arriving while the page is still streaming in means the
    // error stream is running ahead of the data it is meant to correct.
    proto_hit = (data_start && !start_ok) ||
                (err_first && !(state == FILL || state == WAIT)) ||
                (corr_go && state == FILL) ||
                (state == CORRECT && rd_ptr >= wr_ptr);
  end

  // Page buffer: contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Page FSM with registered stream outputs, counters and status flags.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      corr_cnt  <= '0;
      proto_err <= 1'b0;
      dec_cnt   <= '0;
      last_seen <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      corr_cnt  <= corr_nxt;
      dec_cnt   <= dec_nxt;
      last_seen <= seen_nxt;
      if (proto_hit) begin
        proto_err <= 1'b1;
      end
      if (wr_en) begin
        wr_ptr <= wr_addr + 1'b1;
      end
      if (corr_step) begin
        data_out  <= rd_byte ^ err_in;
        out_valid <= 1'b1;
        out_first <= corr_go;
        out_last  <= (rd_ptr == LAST_PTR);
        rd_ptr    <= rd_ptr + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_ok) state <= FILL;
        end
        FILL: begin
          if (corr_go) state <= CORRECT;
          else if (wr_ptr == LAST_PTR) state <= WAIT;
        end
        WAIT: begin
          if (corr_go) state <= CORRECT;
        end
        CORRECT: begin
          if (rd_ptr == LAST_PTR) begin
            state <= DONE;
            done  <= 1'b1;
            fail  <= fail_nxt;
          end
        end
        DONE: begin
          state <= start_ok ? FILL : IDLE;
        end
        default: state <= IDLE;
      endcase
      // A new page starts with clean counters and verdict.
      if (start_ok) begin
        rd_ptr    <= '0;
        corr_cnt  <= '0;
        dec_cnt   <= '0;
        last_seen <= 1'b0;
        fail      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nuc970_corrector.sv
// Bench for nuc970_corrector: random pages checked against a mask-and-popcount model.
// Expected bytes and page verdicts are queued at stimulus time and popped by a monitor.
// The DUT has no backpressure; the monitor samples on the falling clock edge.
module tb_nuc970_corrector;
  localparam int N = 536;
  localparam int T = 4;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_start = 1'b0;
  logic [7:0] err_in = '0;
  logic       err_first = 1'b0;
  logic [7:0] err_cnt = '0;
  logic       err_last = 1'b0;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_first;
  logic       out_last;
  logic [7:0] corr_cnt;
  logic       fail;
  logic       done;
  logic       proto_err;

  nuc970_corrector #(.DATA_BYTES(N), .BITS(8), .T(T)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in), .data_start(data_start),
    .err_in(err_in), .err_first(err_first), .err_cnt(err_cnt), .err_last(err_last),
    .data_out(data_out), .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
    .corr_cnt(corr_cnt), .fail(fail), .done(done), .proto_err(proto_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [7:0] d; bit f; bit l; } exp_byte_t;
  typedef struct { logic [7:0] c; bit f; } exp_done_t;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] page [N];
  logic [7:0] mask [N];
  exp_byte_t  exp_q[$];
  exp_done_t  done_q[$];
  bit         exp_proto = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int mask_bits();
    int s = 0;
    for (int i = 0; i < N; i++) s += popc(mask[i]);
    return s;
  endfunction

  // Reference model: output = page XOR mask, verdict from popcount and the decoder count.
  task automatic expect_page(input logic [7:0] cnt, input bit with_last);
    int        sum;
    exp_byte_t e;
    exp_done_t d;
    for (int i = 0; i < N; i++) begin
      e.d = page[i] ^ mask[i];
      e.f = (i == 0);
      e.l = (i == N - 1);
      exp_q.push_back(e);
    end
    sum = mask_bits();
    d.c = (sum > 255) ? 8'd255 : 8'(sum);
    d.f = (int'(cnt) > T) || (cnt != d.c) || !with_last;
    done_q.push_back(d);
  endtask

  task automatic clear_inputs();
    data_in = '0; data_start = 1'b0; err_in = '0;
    err_first = 1'b0; err_cnt = '0; err_last = 1'b0;
  endtask

  task automatic rand_page();
    for (int i = 0; i < N; i++) begin
      page[i] = 8'($urandom);
      mask[i] = '0;
    end
  endtask

  // Streams one page; the error stream starts 'gap' cycles after data_start.
  task automatic send_page(input int gap, input logic [7:0] cnt, input bit with_last,
                           input int abort_at, input int dup_start_at);
    int k;
    expect_page(cnt, with_last);
    for (int c = 0; c <= gap + N - 1; c++) begin
      @(posedge clk_in); #1;
      data_in    = (c < N) ? page[c] : 8'($urandom);
      data_start = (c == 0) || (c == dup_start_at);
      if (c >= gap) begin
        k = c - gap;
        err_in    = mask[k];
        err_first = (k == 0);
        err_last  = with_last && (k == N - 1);
        err_cnt   = cnt;
        if (k == abort_at) begin
          rst_n = 1'b0;
          clear_inputs();
          #1;
          chk("rst_data_out", data_out, 0);
          chk("rst_out_valid", out_valid, 0);
          chk("rst_out_first", out_first, 0);
          chk("rst_out_last", out_last, 0);
          chk("rst_done", done, 0);
          chk("rst_corr_cnt", corr_cnt, 0);
          chk("rst_proto_err", proto_err, 0);
          exp_q.delete();
          done_q.delete();
          exp_proto = 1'b0;
          repeat (2) @(posedge clk_in);
          #1 rst_n = 1'b1;
          repeat (6) @(posedge clk_in);
          return;
        end
      end else begin
        err_in = '0; err_first = 1'b0; err_last = 1'b0;
      end
    end
    @(posedge clk_in); #1;
    clear_inputs();
    for (int i = 0; i < 20 && (exp_q.size() != 0 || done_q.size() != 0); i++) @(posedge clk_in);
    @(negedge clk_in);
    chk("page_drained", exp_q.size() + done_q.size(), 0);
    exp_q.delete();
    done_q.delete();
    chk("proto_err", proto_err, exp_proto);
    repeat (3) @(posedge clk_in);
  endtask

  // Monitor: every presented byte and every done pulse is checked against the queues.
  always @(negedge clk_in) begin : monitor
    exp_byte_t e;
    exp_done_t d;
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("data_out", data_out, e.d);
          chk("out_first", out_first, e.f);
          chk("out_last", out_last, e.l);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          d = done_q.pop_front();
          chk("corr_cnt", corr_cnt, d.c);
          chk("fail", fail, d.f);
        end
      end
    end
  end

  initial begin
    int p;
    #3;
    chk("init_data_out", data_out, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_done", done, 0);
    chk("init_fail", fail, 0);
    chk("init_corr_cnt", corr_cnt, 0);
    chk("init_proto_err", proto_err, 0);
    #20 rst_n = 1'b1;
    repeat (3) @(posedge clk_in);

    // All-0xFF page, no errors.
    for (int i = 0; i < N; i++) begin page[i] = 8'hFF; mask[i] = '0; end
    send_page(540, 8'd0, 1'b1, -1, -1);

    // Three corrupted bytes repaired back to 0xFF, four bits total.
    page[504] = 8'hEB; mask[504] = 8'h14;
    page[293] = 8'hEF; mask[293] = 8'h10;
    page[168] = 8'hEF; mask[168] = 8'h10;
    send_page(540, 8'd4, 1'b1, -1, -1);

    // Five single-bit flips with err_cnt=5: beyond T.
    rand_page();
    for (int i = 0; i < 5; i++) mask[i * 100 + $urandom_range(0, 99)] = 8'(1 << $urandom_range(0, 7));
    send_page(540, 8'd5, 1'b1, -1, -1);

    // Two masks but decoder claims three.
    rand_page();
    mask[10] = 8'h01; mask[400] = 8'h80;
    send_page(540, 8'd3, 1'b1, -1, -1);

    // Random correctable pages with matching decoder count.
    for (int r = 0; r < 3; r++) begin
      rand_page();
      for (int i = 0; i < 2; i++) mask[$urandom_range(0, N - 1)] |= 8'(1 << $urandom_range(0, 7));
      p = mask_bits();
      send_page(536 + int'($urandom_range(0, 6)), 8'(p), 1'b1, -1, -1);
    end

    // Missing err_last.
    rand_page();
    send_page(540, 8'd0, 1'b0, -1, -1);

    // Error stream starts one cycle after data_start.
    rand_page();
    mask[0] = 8'h22; mask[535] = 8'h01;
    exp_proto = 1'b1;
    send_page(1, 8'd3, 1'b1, -1, -1);

    // Reset at output byte 100, then a normal page.
    rand_page();
    send_page(540, 8'd0, 1'b1, 101, -1);
    rand_page();
    mask[77] = 8'h0F;
    send_page(540, 8'd4, 1'b1, -1, -1);

    // data_start while correcting: ignored, page unchanged.
    rand_page();
    mask[300] = 8'h40;
    exp_proto = 1'b1;
    send_page(540, 8'd1, 1'b1, -1, 740);

    // Saturating correction count.
    rand_page();
    for (int i = 0; i < 40; i++) mask[i * 13] = 8'hFF;
    send_page(540, 8'd4, 1'b1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
